pipe_fifo: RTL
==============

# pipe_fifo

Elastic buffer stage for the 8-bit message pipeline. It accepts messages from an upstream pipe stage, or from the pipeline's overall input, and holds up to DEPTH of them in arrival order. It presents them in that order to a downstream stage, so a stalled consumer does not immediately back-pressure the producer. It also keeps a running count of delivered messages for the testbench's `$display` trace.

## Interface
- WIDTH, 8: message width in bits.
- DEPTH, 4: number of storage entries; must be a power of two, at least 2.
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- iReady  in  1  upstream has a valid message on iMsg.
- iMsg  in  WIDTH  upstream message.
- iGet  out  1  block can accept a message this cycle.
- oReady  out  1  oMsg holds a valid message.
- oMsg  out  WIDTH  oldest stored message.
- oGet  in  1  downstream takes oMsg this cycle.
- count  out  log2(DEPTH)+1  number of stored entries, 0..DEPTH.
- delivered  out  16  total messages popped since reset.

## Operation
- Push: occurs at a rising edge where iReady=1 and iGet=1. iMsg is written at the write pointer; the write pointer increments modulo DEPTH.
- Pop: occurs at a rising edge where oReady=1 and oGet=1. The read pointer increments modulo DEPTH. delivered increments by 1 and wraps 0xFFFF -> 0x0000.
- iGet = (count != DEPTH) and not reset. It is combinational from registered state and never depends on iReady.
- oReady = (count != 0). oMsg = entry at the read pointer, or 0 when empty.
- count update:
  - push only: +1
  - pop only: -1
  - both or neither: unchanged
- Simultaneous push and pop with 0 < count < DEPTH: both happen, count unchanged, order preserved.
- Full (count=DEPTH): iGet=0, so no push occurs even if a pop happens in the same cycle. No full-bypass. iGet rises the cycle after the pop.
- Empty (count=0): oReady=0, so oGet is ignored. No empty-bypass; a pushed message is not visible on oMsg in the cycle it is pushed.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Full and empty are distinguished by count, not by pointer equality.
- iReady while iGet=0: the message is not taken. Upstream must hold it; the block does not latch it.
- Storage entries are not cleared by reset. Only pointers, count, and delivered are cleared.

## Timing
- Reset values, with reset asserted at an edge:
  - next cycle: count=0, oReady=0, oMsg=0, delivered=0
  - iGet=0 throughout the cycles where reset=1, and 1 once reset deasserts
- Reset mid-operation: all stored messages are discarded at the reset edge. A push or pop requested in that cycle is ignored. delivered does not increment.
- Latency: a message pushed at edge N appears on oMsg with oReady=1 after edge N when the FIFO was empty. Otherwise it reaches the head after all older entries are popped.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- A full FIFO with oGet held at 1 alternates DEPTH -> DEPTH-1 -> DEPTH when iReady stays 1. This is a consequence of no full-bypass.
- All outputs change only after rising edges. There are no combinational paths from iReady or oGet to any output.

## Test plan
- Reset: hold reset 5 cycles with iReady=1, oGet=1 -> iGet=0 and count=0 throughout. After release: iGet=1, oReady=0, delivered=0.
- Fill and drain (DEPTH=4): push 10,11,12,13 with oGet=0 -> count=4 and iGet=0; iReady=1 with iMsg=14 is not taken. Then oGet=1 -> oMsg sequence 10,11,12,13, delivered=4, count=0.
- Streaming: iReady=1, oGet=1, iMsg incrementing from 20 -> first oReady one cycle after the first push. After that, one message per cycle in order, with count steady at 1.
- Full with simultaneous pop: fill with 1..4, then iReady=1 (iMsg=5) and oGet=1 together -> pop of 1 only, count=3. Next cycle 5 is pushed.
- Wrap-around: push and pop 10 messages with a random oGet pattern -> output order equals input order, and pointers have wrapped at least twice.
- Mid-operation reset: with count=3, assert reset one cycle while pushing -> count=0 and oReady=0 after the edge. The next message pushed (iMsg=99) is the first popped. delivered restarts from 0.

Source files
------------

// File: rtl/pipe_fifo.sv
// pipe_fifo: elastic FIFO stage for the message pipeline. Storage is registered.
// Full and empty are told apart by the entry count, not by comparing the pointers.
module pipe_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             iReady,
   input  logic [WIDTH-1:0] iMsg,
   output logic             iGet,
   output logic             oReady,
   output logic [WIDTH-1:0] oMsg,
   input  logic             oGet,
   output logic [CW-1:0]    count,
   output logic [15:0]      delivered
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push;
   logic             pop;

   // Handshake: a transfer happens on a rising edge where valid (iReady/oReady) and
   // ready (iGet/oGet) are both high. iGet and oReady come only from registered
   // state and reset, never from iReady or oGet. A producer must hold iMsg while iGet is low.
   assign iGet   = (count != CW'(DEPTH)) && !reset;
   assign oReady = (count != '0);
   assign oMsg   = oReady ? mem[rd_ptr] : '0;
   assign push   = iReady && iGet;
   assign pop    = oReady && oGet;

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         delivered <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) begin
            rd_ptr    <= rd_ptr + AW'(1);
            delivered <= delivered + 16'd1;
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is deliberately not reset; only pointers and counters are.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= iMsg;
   end

endmodule
